// File: rtl/attempt_lockout_ctrl_if.sv
// Handshake bundle between the password comparator / keypad logic and attempt_lockout_ctrl.
// The comparator side is the master; the lockout controller is the slave.
interface attempt_lockout_ctrl_if #(
    parameter int MAX_FAILS  = 5,
    parameter int MAX_LEVELS = 2,
    parameter int TIMER_W    = 16
);
    localparam int FC_W = $clog2(MAX_FAILS + 1);
    localparam int LV_W = $clog2(MAX_LEVELS + 1);

    logic               attempt_valid;
    logic               attempt_match;
    logic               master_match;
    logic               clear_req;
    logic               input_enable;
    logic               grant;
    logic               deny;
    logic [FC_W-1:0]    fail_count;
    logic [LV_W-1:0]    lock_level;
    logic               lockout_active;
    logic               master_only;
    logic [TIMER_W-1:0] lock_timer;

    modport master (
        output attempt_valid, attempt_match, master_match, clear_req,
        input  input_enable, grant, deny, fail_count, lock_level,
               lockout_active, master_only, lock_timer
    );

    modport slave (
        input  attempt_valid, attempt_match, master_match, clear_req,
        output input_enable, grant, deny, fail_count, lock_level,
               lockout_active, master_only, lock_timer
    );
endinterface

// File: rtl/attempt_lockout_ctrl.sv
// DoorLock attempt sequencer: counts failed attempts, schedules doubling lockout windows
// and drops to master-password-only mode once every timed lockout has been used up.
module attempt_lockout_ctrl #(
    parameter int MAX_FAILS        = 5,
    parameter int BASE_LOCK_CYCLES = 16,
    parameter int MAX_LEVELS       = 2,
    parameter int TIMER_W          = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    attempt_lockout_ctrl_if.slave   bus
);
    localparam int FC_W = $clog2(MAX_FAILS + 1);
    localparam int LV_W = $clog2(MAX_LEVELS + 1);
    localparam logic [31:0]        MAX_FAILS_U  = MAX_FAILS;
    localparam logic [31:0]        MAX_LEVELS_U = MAX_LEVELS;
    localparam logic [TIMER_W-1:0] BASE_T       = TIMER_W'(BASE_LOCK_CYCLES);

    typedef enum logic [1:0] {
        ST_ARMED       = 2'd0,
        ST_LOCKOUT     = 2'd1,
        ST_MASTER_ONLY = 2'd2
    } state_e;

    state_e             state_q;
    logic               input_enable_q;
    logic               grant_q;
    logic               deny_q;
    logic [FC_W-1:0]    fail_count_q;
    logic [LV_W-1:0]    lock_level_q;
    logic               lockout_active_q;
    logic               master_only_q;
    logic [TIMER_W-1:0] lock_timer_q;

    logic fail_limit_s;
    logic level_room_s;
    logic any_match_s;

    assign fail_limit_s = ((32'(fail_count_q) + 32'd1) >= MAX_FAILS_U);
    assign level_room_s = (32'(lock_level_q) < MAX_LEVELS_U);
    assign any_match_s  = bus.master_match | bus.attempt_match;

    // Lockout state machine; every output is a register updated here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= ST_ARMED;
            input_enable_q   <= 1'b1;
            grant_q          <= 1'b0;
            deny_q           <= 1'b0;
            fail_count_q     <= '0;
            lock_level_q     <= '0;
            lockout_active_q <= 1'b0;
            master_only_q    <= 1'b0;
            lock_timer_q     <= '0;
        end else begin
            grant_q <= 1'b0;
            deny_q  <= 1'b0;
            if (bus.clear_req) begin
                // A new password wipes all history and swallows any same-cycle attempt.
                state_q          <= ST_ARMED;
                input_enable_q   <= 1'b1;
                fail_count_q     <= '0;
                lock_level_q     <= '0;
                lockout_active_q <= 1'b0;
                master_only_q    <= 1'b0;
                lock_timer_q     <= '0;
            end else begin
                case (state_q)
                    ST_ARMED: begin
                        if (bus.attempt_valid && any_match_s) begin
                            grant_q      <= 1'b1;
                            fail_count_q <= '0;
                            lock_level_q <= '0;
                        end else if (bus.attempt_valid) begin
                            deny_q <= 1'b1;
                            if (!fail_limit_s) begin
                                fail_count_q <= fail_count_q + FC_W'(1);
                            end else if (level_room_s) begin
                                fail_count_q     <= '0;
                                state_q          <= ST_LOCKOUT;
                                input_enable_q   <= 1'b0;
                                lockout_active_q <= 1'b1;
                                lock_timer_q     <= BASE_T << lock_level_q;
                                lock_level_q     <= lock_level_q + LV_W'(1);
                            end else begin
                                fail_count_q  <= '0;
                                state_q       <= ST_MASTER_ONLY;
                                master_only_q <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_ARMED;
                        end
                    end
                    ST_LOCKOUT: begin
                        // Attempts are ignored here, including the one on the expiry cycle.
                        if (lock_timer_q <= TIMER_W'(1)) begin
                            state_q          <= ST_ARMED;
                            input_enable_q   <= 1'b1;
                            lockout_active_q <= 1'b0;
                            lock_timer_q     <= '0;
                        end else begin
                            lock_timer_q <= lock_timer_q - TIMER_W'(1);
                        end
                    end
                    ST_MASTER_ONLY: begin
                        if (bus.attempt_valid && bus.master_match) begin
                            grant_q       <= 1'b1;
                            fail_count_q  <= '0;
                            lock_level_q  <= '0;
                            state_q       <= ST_ARMED;
                            master_only_q <= 1'b0;
                        end else if (bus.attempt_valid) begin
                            deny_q <= 1'b1;
                        end else begin
                            state_q <= ST_MASTER_ONLY;
                        end
                    end
                    default: begin
                        state_q          <= ST_ARMED;
                        input_enable_q   <= 1'b1;
                        fail_count_q     <= '0;
                        lock_level_q     <= '0;
                        lockout_active_q <= 1'b0;
                        master_only_q    <= 1'b0;
                        lock_timer_q     <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.input_enable   = input_enable_q;
    assign bus.grant          = grant_q;
    assign bus.deny           = deny_q;
    assign bus.fail_count     = fail_count_q;
    assign bus.lock_level     = lock_level_q;
    assign bus.lockout_active = lockout_active_q;
    assign bus.master_only    = master_only_q;
    assign bus.lock_timer     = lock_timer_q;
endmodule

// File: tb/tb_attempt_lockout_ctrl.sv
// Scenario bench for attempt_lockout_ctrl: expected grant/deny pulses are queued as each
// attempt is driven and popped when the registered pulse appears.
module tb_attempt_lockout_ctrl;
    localparam int MAX_FAILS  = 5;
    localparam int BASE       = 16;
    localparam int MAX_LEVELS = 2;
    localparam int TIMER_W    = 16;

    localparam logic [1:0] P_NONE  = 2'b00;
    localparam logic [1:0] P_DENY  = 2'b01;
    localparam logic [1:0] P_GRANT = 2'b10;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    logic [1:0] sb[$];
    logic [1:0] exp_p;
    logic [1:0] got_p;

    attempt_lockout_ctrl_if #(.MAX_FAILS(MAX_FAILS), .MAX_LEVELS(MAX_LEVELS), .TIMER_W(TIMER_W)) bus ();

    attempt_lockout_ctrl #(
        .MAX_FAILS(MAX_FAILS), .BASE_LOCK_CYCLES(BASE),
        .MAX_LEVELS(MAX_LEVELS), .TIMER_W(TIMER_W)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign got_p = {bus.grant, bus.deny};

    // Drives one attempt cycle and records the pulse it must produce.
    task automatic attempt(input logic um, input logic mm, input logic clr, input logic [1:0] exp);
        @(negedge clk);
        bus.attempt_valid = 1'b1;
        bus.attempt_match = um;
        bus.master_match  = mm;
        bus.clear_req     = clr;
        sb.push_back(exp);
        @(negedge clk);
        bus.attempt_valid = 1'b0;
        bus.attempt_match = 1'b0;
        bus.master_match  = 1'b0;
        bus.clear_req     = 1'b0;
    endtask

    // Counts negedges with lockout_active high while hammering attempts; counts stray pulses.
    task automatic ride_lockout(output int cnt, output int stray);
        cnt   = 0;
        stray = 0;
        for (int i = 0; i < 200; i++) begin
            if (i != 0 && got_p !== P_NONE) stray++;
            if (!bus.lockout_active) break;
            cnt++;
            bus.attempt_valid = 1'b1;
            bus.master_match  = i[0];
            bus.attempt_match = i[1];
            @(negedge clk);
        end
        bus.attempt_valid = 1'b0;
        bus.master_match  = 1'b0;
        bus.attempt_match = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.attempt_valid = 1'b0;
        bus.attempt_match = 1'b0;
        bus.master_match  = 1'b0;
        bus.clear_req     = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.input_enable, bus.grant, bus.deny, bus.lockout_active, bus.master_only} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=10000", {bus.input_enable, bus.grant, bus.deny, bus.lockout_active, bus.master_only});
        end
        checks++;
        if (bus.fail_count !== 3'd0 || bus.lock_level !== 2'd0 || bus.lock_timer !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts got fc=%0d lv=%0d t=%0d exp 0/0/0", bus.fail_count, bus.lock_level, bus.lock_timer);
        end
    endtask

    task automatic test_wrong_then_match();
        for (int i = 0; i < 4; i++) begin
            attempt(1'b0, 1'b0, 1'b0, P_DENY);
            exp_p = sb.pop_front();
            checks++;
            if (got_p !== exp_p || bus.fail_count !== 3'(i + 1)) begin
                errors++;
                $display("FAIL wrong_%0d got pulse=%b fc=%0d exp pulse=%b fc=%0d", i, got_p, bus.fail_count, exp_p, i + 1);
            end
        end
        attempt(1'b1, 1'b0, 1'b0, P_GRANT);
        exp_p = sb.pop_front();
        checks++;
        if (got_p !== exp_p || bus.fail_count !== 3'd0) begin
            errors++;
            $display("FAIL user_grant got pulse=%b fc=%0d exp pulse=%b fc=0", got_p, bus.fail_count, exp_p);
        end
    endtask

    // Five wrong attempts from ARMED; expects a lockout entry of the given length.
    task automatic escalate_to_lockout(input int exp_len, input logic [1:0] exp_lv);
        int cnt;
        int stray;
        for (int i = 0; i < 5; i++) begin
            attempt(1'b0, 1'b0, 1'b0, P_DENY);
            exp_p = sb.pop_front();
            checks++;
            if (got_p !== exp_p) begin
                errors++;
                $display("FAIL esc_deny_%0d got=%b exp=%b", i, got_p, exp_p);
            end
        end
        checks++;
        if (bus.lock_timer !== 16'(exp_len) || bus.input_enable !== 1'b0 || bus.lock_level !== exp_lv) begin
            errors++;
            $display("FAIL lock_entry got t=%0d ie=%b lv=%0d exp t=%0d ie=0 lv=%0d", bus.lock_timer, bus.input_enable, bus.lock_level, exp_len, exp_lv);
        end
        ride_lockout(cnt, stray);
        checks++;
        if (cnt != exp_len || stray != 0) begin
            errors++;
            $display("FAIL lock_window got len=%0d stray=%0d exp len=%0d stray=0", cnt, stray, exp_len);
        end
        checks++;
        if (bus.input_enable !== 1'b1 || bus.lock_timer !== 16'd0 || bus.fail_count !== 3'd0 || bus.lock_level !== exp_lv) begin
            errors++;
            $display("FAIL lock_exit got ie=%b t=%0d fc=%0d lv=%0d exp ie=1 t=0 fc=0 lv=%0d", bus.input_enable, bus.lock_timer, bus.fail_count, bus.lock_level, exp_lv);
        end
    endtask

    task automatic test_lockout_escalation();
        escalate_to_lockout(16, 2'd1);
        escalate_to_lockout(32, 2'd2);
    endtask

    task automatic test_master_only();
        for (int i = 0; i < 5; i++) begin
            attempt(1'b0, 1'b0, 1'b0, P_DENY);
            exp_p = sb.pop_front();
            checks++;
            if (got_p !== exp_p) begin
                errors++;
                $display("FAIL mo_deny_%0d got=%b exp=%b", i, got_p, exp_p);
            end
        end
        checks++;
        if (bus.master_only !== 1'b1 || bus.lockout_active !== 1'b0 || bus.input_enable !== 1'b1 || bus.lock_level !== 2'd2) begin
            errors++;
            $display("FAIL mo_entry got mo=%b la=%b ie=%b lv=%0d exp 1/0/1/2", bus.master_only, bus.lockout_active, bus.input_enable, bus.lock_level);
        end
        attempt(1'b1, 1'b0, 1'b0, P_DENY);
        exp_p = sb.pop_front();
        checks++;
        if (got_p !== exp_p || bus.master_only !== 1'b1 || bus.lock_level !== 2'd2) begin
            errors++;
            $display("FAIL mo_user got pulse=%b mo=%b lv=%0d exp pulse=%b mo=1 lv=2", got_p, bus.master_only, bus.lock_level, exp_p);
        end
        attempt(1'b0, 1'b1, 1'b0, P_GRANT);
        exp_p = sb.pop_front();
        checks++;
        if (got_p !== exp_p || bus.master_only !== 1'b0 || bus.lock_level !== 2'd0) begin
            errors++;
            $display("FAIL mo_master got pulse=%b mo=%b lv=%0d exp pulse=%b mo=0 lv=0", got_p, bus.master_only, bus.lock_level, exp_p);
        end
    endtask

    task automatic test_both_match_and_clear();
        attempt(1'b1, 1'b1, 1'b0, P_GRANT);
        exp_p = sb.pop_front();
        checks++;
        if (got_p !== exp_p) begin
            errors++;
            $display("FAIL both_match got=%b exp=%b", got_p, exp_p);
        end
        attempt(1'b0, 1'b0, 1'b0, P_DENY);
        void'(sb.pop_front());
        attempt(1'b0, 1'b0, 1'b0, P_DENY);
        exp_p = sb.pop_front();
        checks++;
        if (got_p !== exp_p || bus.fail_count !== 3'd2) begin
            errors++;
            $display("FAIL pre_clear got pulse=%b fc=%0d exp pulse=%b fc=2", got_p, bus.fail_count, exp_p);
        end
        attempt(1'b0, 1'b0, 1'b1, P_NONE);
        exp_p = sb.pop_front();
        checks++;
        if (got_p !== exp_p || bus.fail_count !== 3'd0 || bus.lock_level !== 2'd0) begin
            errors++;
            $display("FAIL clear_req got pulse=%b fc=%0d lv=%0d exp pulse=%b fc=0 lv=0", got_p, bus.fail_count, bus.lock_level, exp_p);
        end
    endtask

    task automatic test_async_reset_mid_lockout();
        bit found;
        for (int i = 0; i < 5; i++) begin
            attempt(1'b0, 1'b0, 1'b0, P_DENY);
            void'(sb.pop_front());
        end
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.lock_timer == 16'd7 && bus.lockout_active) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL timer7_wait got t=%0d exp 7 within budget", bus.lock_timer);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.input_enable, bus.lockout_active, bus.master_only} !== 3'b100 || bus.lock_timer !== 16'd0 || bus.lock_level !== 2'd0 || bus.fail_count !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got ie/la/mo=%b t=%0d lv=%0d fc=%0d exp 100 t=0 lv=0 fc=0",
                     {bus.input_enable, bus.lockout_active, bus.master_only}, bus.lock_timer, bus.lock_level, bus.fail_count);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_wrong_then_match();
        test_lockout_escalation();
        test_master_only();
        test_both_match_and_clear();
        test_async_reset_mid_lockout();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
